// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions: datapath width, default boot address, sequencer states.
// No logic; types and constants only.
// Imported by every IF-stage module.
package cpu_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   // BOOT: idle after reset, REQ: request on the bus, SKID: a fetched word is parked
   typedef enum logic [1:0] {
      S_BOOT = 2'd0,
      S_REQ  = 2'd1,
      S_SKID = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry {pc, instr} parking register for a word fetched while the IF/ID slot is stalled.
// Latency: loaded word readable the cycle after load.
// Backpressure: none of its own; flush has priority over load, load over unload.
module if_skid_buf
   import cpu_pkg::*;
(
   input  logic            myclk,
   input  logic            reset,
   input  logic            load,
   input  logic            unload,
   input  logic            flush,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] in_instr,
   output logic            valid,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] instr
);

   // hold the parked word until it is moved into the slot or discarded by a redirect
   always_ff @(posedge myclk) begin
      if (reset) begin
         valid <= 1'b0;
         pc    <= '0;
         instr <= '0;
      end else if (flush) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         pc    <= in_pc;
         instr <= in_instr;
      end else if (unload) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/fetch_sequencer.sv
// IF-stage sequencer: owns the PC, fetches over req/ack, redirects on taken branches.
// Latency: memory latency + 1 cycle from request to the IF/ID slot; 1 instr/cycle when unstalled.
// Backpressure: a stalled full slot parks one extra word in the skid buffer and drops the request.
module fetch_sequencer
   import cpu_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int unsigned     INC      = 4
)(
   input  logic            myclk,
   input  logic            reset,
   input  logic            stall,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] branch_target,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            if_valid,
   output logic [XLEN-1:0] if_pc,
   output logic [XLEN-1:0] if_instr
);

   localparam logic [XLEN-1:0] INC_W = XLEN'(INC);

   fetch_state_t    state;
   logic [XLEN-1:0] redir_pc;
   logic            drop;

   logic            fetch_done;
   logic            slot_free;
   logic            sk_load;
   logic            sk_unload;
   logic            sk_valid;
   logic [XLEN-1:0] sk_pc;
   logic [XLEN-1:0] sk_instr;

   assign imem_req = (state == S_REQ);

   // decode handshake completion and skid-buffer control for this cycle
   always_comb begin
      fetch_done = imem_req && imem_ack;
      slot_free  = !if_valid || !stall;
      sk_load    = !branch_taken && fetch_done && !drop && !slot_free;
      sk_unload  = !branch_taken && (state == S_SKID) && !stall;
   end

   if_skid_buf u_skid (
      .myclk    (myclk),
      .reset    (reset),
      .load     (sk_load),
      .unload   (sk_unload),
      .flush    (branch_taken),
      .in_pc    (imem_addr),
      .in_instr (imem_rdata),
      .valid    (sk_valid),
      .pc       (sk_pc),
      .instr    (sk_instr)
   );

   // sequencer FSM: PC advance, redirect bookkeeping and IF/ID slot update
   always_ff @(posedge myclk) begin
      if (reset) begin
         state     <= S_BOOT;
         imem_addr <= RESET_PC;
         redir_pc  <= '0;
         drop      <= 1'b0;
         if_valid  <= 1'b0;
         if_pc     <= '0;
         if_instr  <= '0;
      end else if (branch_taken) begin
         // a redirect squashes everything fetched so far, even under stall
         if_valid <= 1'b0;
         if (state != S_REQ) begin
            imem_addr <= branch_target;
            drop      <= 1'b0;
            state     <= S_REQ;
         end else if (imem_ack) begin
            imem_addr <= branch_target;
            drop      <= 1'b0;
         end else begin
            // address must stay stable on the bus; retarget once the old fetch returns
            redir_pc <= branch_target;
            drop     <= 1'b1;
         end
      end else begin
         if (if_valid && !stall) begin
            if_valid <= 1'b0;
         end
         case (state)
            S_BOOT: begin
               state <= S_REQ;
            end
            S_REQ: begin
               if (imem_ack) begin
                  if (drop) begin
                     imem_addr <= redir_pc;
                     drop      <= 1'b0;
                  end else begin
                     imem_addr <= imem_addr + INC_W;
                     if (slot_free) begin
                        if_valid <= 1'b1;
                        if_pc    <= imem_addr;
                        if_instr <= imem_rdata;
                     end else begin
                        state <= S_SKID;
                     end
                  end
               end
            end
            S_SKID: begin
               if (!stall) begin
                  if_valid <= sk_valid;
                  if_pc    <= sk_pc;
                  if_instr <= sk_instr;
                  state    <= S_REQ;
               end
            end
            default: begin
               state <= S_BOOT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed vector table, hand sequences for redirect corners,
// then randomized stall/branch/latency traffic checked against a program-stream model.
// Memory model acks after a programmable number of wait cycles.
module tb_fetch_sequencer;

   localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;

   logic        myclk = 1'b0;
   logic        reset;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instr;

   always #5 myclk = ~myclk;

   fetch_sequencer #(.RESET_PC(RST_PC), .INC(4)) dut (
      .myclk         (myclk),
      .reset         (reset),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_rdata    (imem_rdata),
      .if_valid      (if_valid),
      .if_pc         (if_pc),
      .if_instr      (if_instr)
   );

   int          total = 0;
   int          bad = 0;
   int          mem_lat = 0;
   int          mem_cnt = 0;
   int          delivered = 0;
   logic [31:0] exp_pc = 32'h0;

   typedef struct {
      logic        st;
      logic        br;
      logic [31:0] tgt;
      logic        req;
      logic [31:0] addr;
      logic        vld;
      logic [31:0] pc;
   } vec_t;

   vec_t tbl[13];

   // instruction memory contents: a fixed scramble of the address
   function automatic logic [31:0] word_at(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hA5A5_0F0F;
   endfunction

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // one clock: drive inputs and memory response, then score the edge from the program's view
   task automatic tick(input logic rst, input logic st, input logic br, input logic [31:0] tgt);
      logic        p_req;
      logic        p_valid;
      logic [31:0] p_addr;
      logic [31:0] p_pc;
      logic [31:0] p_instr;
      reset         = rst;
      stall         = st;
      branch_taken  = br;
      branch_target = tgt;
      if (imem_req && mem_cnt >= mem_lat) begin
         imem_ack   = 1'b1;
         imem_rdata = word_at(imem_addr);
      end else begin
         imem_ack   = 1'b0;
         imem_rdata = $urandom;
      end
      p_req   = imem_req;
      p_valid = if_valid;
      p_addr  = imem_addr;
      p_pc    = if_pc;
      p_instr = if_instr;
      @(posedge myclk);
      #1;
      if (rst) begin
         mem_cnt = 0;
         exp_pc  = RST_PC;
      end else begin
         if (p_req && imem_ack) mem_cnt = 0;
         else if (p_req) mem_cnt++;
         if (p_req && !imem_ack) check32("addr_hold", imem_addr, p_addr);
         if (br) begin
            exp_pc = tgt;
         end else if (p_valid && !st) begin
            check32("stream_pc", p_pc, exp_pc);
            check32("stream_instr", p_instr, word_at(p_pc));
            exp_pc = p_pc + 32'd4;
            delivered++;
         end
      end
      @(negedge myclk);
   endtask

   // bounded wait for the slot to fill; returns 1 if it did
   task automatic wait_valid(input string name, output logic seen);
      seen = 1'b0;
      for (int i = 0; i < 12 && !seen; i++) begin
         if (if_valid) seen = 1'b1;
         else tick(1'b0, 1'b0, 1'b0, 32'h0);
      end
      if (!seen) begin
         total++;
         bad++;
         $display("FAIL %s: slot never filled got if_valid=0 want 1", name);
      end
   endtask

   initial begin
      logic seen;
      int   start_cnt;
      logic st;
      logic br;

      reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
      imem_ack = 1'b0; imem_rdata = 32'h0;

      //           st    br    tgt          req   addr          vld   pc
      tbl[0]  = '{1'b0, 1'b0, 32'h0,       1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0};
      tbl[1]  = '{1'b0, 1'b0, 32'h0,       1'b1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFF8};
      tbl[2]  = '{1'b0, 1'b0, 32'h0,       1'b1, 32'h0000_0000, 1'b1, 32'hFFFF_FFFC};
      tbl[3]  = '{1'b0, 1'b0, 32'h0,       1'b1, 32'h0000_0004, 1'b1, 32'h0000_0000};
      tbl[4]  = '{1'b1, 1'b0, 32'h0,       1'b0, 32'h0000_0008, 1'b1, 32'h0000_0000};
      tbl[5]  = '{1'b1, 1'b0, 32'h0,       1'b0, 32'h0000_0008, 1'b1, 32'h0000_0000};
      tbl[6]  = '{1'b1, 1'b0, 32'h0,       1'b0, 32'h0000_0008, 1'b1, 32'h0000_0000};
      tbl[7]  = '{1'b0, 1'b0, 32'h0,       1'b1, 32'h0000_0008, 1'b1, 32'h0000_0004};
      tbl[8]  = '{1'b0, 1'b0, 32'h0,       1'b1, 32'h0000_000C, 1'b1, 32'h0000_0008};
      tbl[9]  = '{1'b1, 1'b0, 32'h0,       1'b0, 32'h0000_0010, 1'b1, 32'h0000_0008};
      tbl[10] = '{1'b1, 1'b1, 32'h200,     1'b1, 32'h0000_0200, 1'b0, 32'h0};
      tbl[11] = '{1'b0, 1'b0, 32'h0,       1'b1, 32'h0000_0204, 1'b1, 32'h0000_0200};
      tbl[12] = '{1'b0, 1'b0, 32'h0,       1'b1, 32'h0000_0208, 1'b1, 32'h0000_0204};

      @(negedge myclk);

      // reset state
      tick(1'b1, 1'b0, 1'b0, 32'h0);
      tick(1'b1, 1'b0, 1'b0, 32'h0);
      check32("rst_req", {31'b0, imem_req}, 32'd0);
      check32("rst_addr", imem_addr, RST_PC);
      check32("rst_valid", {31'b0, if_valid}, 32'd0);
      check32("rst_pc", if_pc, 32'h0);
      check32("rst_instr", if_instr, 32'h0);

      // zero-wait memory: wrap, stall into skid, redirect with slot and skid full
      mem_lat = 0;
      for (int i = 0; i < 13; i++) begin
         tick(1'b0, tbl[i].st, tbl[i].br, tbl[i].tgt);
         check32($sformatf("vec%0d_req", i), {31'b0, imem_req}, {31'b0, tbl[i].req});
         check32($sformatf("vec%0d_addr", i), imem_addr, tbl[i].addr);
         check32($sformatf("vec%0d_valid", i), {31'b0, if_valid}, {31'b0, tbl[i].vld});
         if (tbl[i].vld) begin
            check32($sformatf("vec%0d_pc", i), if_pc, tbl[i].pc);
            check32($sformatf("vec%0d_instr", i), if_instr, word_at(tbl[i].pc));
         end
      end

      // branch one cycle into a 3-cycle fetch: old data dropped, target fetched next
      tick(1'b1, 1'b0, 1'b0, 32'h0);
      mem_lat = 2;
      tick(1'b0, 1'b0, 1'b0, 32'h0);
      tick(1'b0, 1'b0, 1'b1, 32'h100);
      tick(1'b0, 1'b0, 1'b0, 32'h0);
      tick(1'b0, 1'b0, 1'b0, 32'h0);
      check32("redir_addr", imem_addr, 32'h100);
      check32("redir_req", {31'b0, imem_req}, 32'd1);
      check32("redir_valid", {31'b0, if_valid}, 32'd0);
      wait_valid("redir_fill", seen);
      if (seen) check32("redir_first_pc", if_pc, 32'h100);

      // reset while a request is outstanding and the slot is full
      tick(1'b1, 1'b1, 1'b0, 32'h0);
      check32("midrst_req", {31'b0, imem_req}, 32'd0);
      check32("midrst_valid", {31'b0, if_valid}, 32'd0);
      check32("midrst_addr", imem_addr, RST_PC);

      // two branches during one outstanding fetch: only the latest target survives
      mem_lat = 2;
      tick(1'b0, 1'b0, 1'b0, 32'h0);
      tick(1'b0, 1'b0, 1'b1, 32'h300);
      tick(1'b0, 1'b0, 1'b1, 32'h400);
      tick(1'b0, 1'b0, 1'b0, 32'h0);
      check32("dbl_addr", imem_addr, 32'h400);
      wait_valid("dbl_fill", seen);
      if (seen) check32("dbl_first_pc", if_pc, 32'h400);

      // randomized traffic scored against the expected program stream
      tick(1'b1, 1'b0, 1'b0, 32'h0);
      start_cnt = delivered;
      for (int n = 0; n < 3000; n++) begin
         if (n % 200 == 0) mem_lat = $urandom_range(0, 3);
         st = ($urandom_range(0, 9) < 3);
         br = ($urandom_range(0, 99) < 6);
         tick(1'b0, st, br, $urandom & 32'hFFFF_FFFC);
      end
      total++;
      if (delivered - start_cnt < 300) begin
         bad++;
         $display("FAIL rand_progress: got %0d deliveries want at least 300", delivered - start_cnt);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch sequencer for the IF stage. It owns the program counter and issues word fetches to instruction memory over a req/ack handshake. It redirects on taken branches and delivers `{pc, instr}` to the IF/ID boundary under a downstream stall, with a one-entry skid buffer. It replaces direct free-running PC increment with a sequenced, stall- and redirect-aware fetch.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `INC`, 4: address increment per instruction (bytes).

Ports:
- `myclk`  in  1  stage clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; clock `myclk`.
- `stall`  in  1  hazard unit: IF/ID slot not consumed this cycle.
- `branch_taken`  in  1  one-cycle pulse from EX: redirect fetch.
- `branch_target`  in  32  redirect address; valid when `branch_taken`.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address; stable while `imem_req && !imem_ack`.
- `imem_ack`  in  1  fetch complete; may assert in the same cycle as `imem_req`.
- `imem_rdata`  in  32  instruction word; valid when `imem_ack`.
- `if_valid`  out  1  IF/ID slot holds an instruction.
- `if_pc`  out  32  address of the slot instruction.
- `if_instr`  out  32  slot instruction.

## Operation
- States:
  - `S_BOOT`: reset state, no request.
  - `S_REQ`: `imem_req`=1.
  - `S_SKID`: fetched word parked, no request.
- Registers:
  - `imem_addr`: outstanding fetch address.
  - `redir_pc`: pending redirect.
  - `drop`: discard the next ack.
  - Slot: `if_valid`/`if_pc`/`if_instr`.
  - Skid: `sk_pc`/`sk_instr`.
- Slot consumed when `if_valid && !stall`. The slot is free next edge if it is empty or being consumed.
- `S_BOOT` → `S_REQ` unconditionally.
- `S_REQ`, ack, `!drop`, no branch, slot free:
  - slot ← {`imem_addr`, `imem_rdata`}.
  - `imem_addr` += INC.
  - Stay in `S_REQ`.
- `S_REQ`, ack, `!drop`, no branch, slot full and stalled:
  - skid ← {`imem_addr`, `imem_rdata`}.
  - `imem_addr` += INC.
  - → `S_SKID`.
- `S_SKID`, `!stall`: slot ← skid; → `S_REQ`.
- `S_SKID`, `stall`: hold.
- `branch_taken` has the highest priority and overrides `stall`:
  - Slot and skid are invalidated.
  - If state is `S_SKID` or `S_BOOT`: `imem_addr` ← target; → `S_REQ`.
  - If `S_REQ` with ack this cycle: data discarded; `imem_addr` ← target; `drop` ← 0.
  - If `S_REQ` without ack: `redir_pc` ← target; `drop` ← 1. The request stays up with the unchanged address.
- `S_REQ`, ack, `drop`=1, no new branch: data discarded; `imem_addr` ← `redir_pc`; `drop` ← 0.
- A second branch while `drop`=1 overwrites `redir_pc`; only the latest target is used.
- Addresses wrap modulo 2^32; 32'hFFFF_FFFC + 4 = 0.
- Reset mid-fetch: all state is cleared and the outstanding request is abandoned. Instruction memory must ignore it (documented memory requirement).

## Timing
- Reset values:
  - `imem_req`=0
  - `imem_addr`=`RESET_PC`
  - `if_valid`=0
  - `if_pc`=0
  - `if_instr`=0
  - `drop`=0
  - state=`S_BOOT`
- `imem_req` is decoded from state (`S_REQ`); all other outputs are registered.
- Cycle 0 = first edge with `reset` low: `S_BOOT`.
- Cycle 1: first request.
- With zero-wait memory, `if_valid` rises at cycle 2. Throughput is one instruction per cycle while `!stall`.
- Fetch latency is memory latency plus one cycle to the slot.
- Branch penalty with zero-wait memory: target in the slot two edges after the `branch_taken` edge.
- Branch penalty with outstanding fetch: two edges after the discarded ack.
- No instruction is duplicated or lost across stall/unstall.
- Nothing fetched before a branch reaches the slot after it.

## Structure
- Shared package (`cpu_pkg`) holds:
  - the state enum (`S_BOOT`, `S_REQ`, `S_SKID`);
  - `XLEN`=32;
  - the default `RESET_PC`.
- One sub-module, `if_skid_buf`: one-entry {pc, instr} buffer with load/unload/flush.
- The sequencer top holds the FSM, address, and redirect logic. Target size is about 200 lines of RTL.

## Test plan
- Reset release, zero-wait ack tied to req: `imem_addr` sequence 0,4,8,…; `if_pc` 0,4,8 from cycle 2; `if_valid` continuous.
- Stall held 3 cycles with slot full: one word parked in skid, `imem_req`=0. On unstall, `if_pc` continues N, N+4 with no gap, duplicate, or loss.
- 3-cycle memory, `branch_taken`(target 0x100) one cycle after req: the ack for the old address is dropped, the next `imem_addr`=0x100, and the first slot `if_pc`=0x100.
- `branch_taken`(0x200) with `stall`=1, slot and skid full: both invalidated, `if_valid`=0 next cycle, and the next fetch is at 0x200.
- Two branches (0x300, then 0x400) during one outstanding fetch: only 0x400 is fetched.
- `RESET_PC`=32'hFFFF_FFF8: addresses FFF8, FFFC, 0000; reset asserted mid-request: `imem_req`=0 and `if_valid`=0 at the next edge.
